stage_if: RTL and testbench
===========================

STAGE_IF -- requirements
Module: stage_if

Interface
REQ-001 The parameter list SHALL be: RESET_PC, 32'hBFC00000, PC loaded on reset.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state updates on posedge clk.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port stall, input, 1 bit: downstream (ID) not accepting; output register holds.
REQ-005 The block SHALL have ports redirect_valid, input, 1 bit, and redirect_pc, input, 32 bits: branch, jump or exception target; overrides stall.
REQ-006 The block SHALL have ports mem_req, output, 1 bit, and mem_addr, output, 32 bits: instruction fetch request, held until acknowledged.
REQ-007 The block SHALL have ports mem_ack, input, 1 bit, and mem_rdata, input, 32 bits: fetch complete, with data valid in the ack cycle.
REQ-008 The block SHALL have port mem_exc_code, input, EXC_CODE_WIDTH bits: fetch fault code (TLB or bus), valid with mem_ack; EC_NONE if the fetch was clean.
REQ-009 The block SHALL have port interstage_if2id, output, IF2ID_WIRE_WIDTH bits: packed fields instr[31:0], next_pc[31:0], exc_code, exc_addr[31:0], using the standard if2id field layout.

Function
REQ-010 Internal state SHALL be: pc, state {FETCH, WAIT, HOLD}, discard flag, one-entry skid buffer (valid, instr, next_pc, exc_code, exc_addr), and the output register.
REQ-011 A bubble SHALL be: instr=0 (NOP), next_pc=0, exc_code=EC_NONE, exc_addr=0.
REQ-012 FETCH with pc[1:0]==0 and the skid buffer empty SHALL drive mem_req=1 and mem_addr=pc, then go to WAIT.
REQ-013 FETCH with pc[1:0]!=0 SHALL issue no request and produce an entry in the same cycle: instr=0, exc_code=EC_ADEL, exc_addr=pc, next_pc=pc+4.
REQ-014 After producing the misaligned-fetch entry, the block SHALL go to HOLD and fetch no further until a redirect.
REQ-015 In WAIT, mem_req and mem_addr SHALL stay stable until mem_ack.
REQ-016 On mem_ack with discard=0, the block SHALL produce an entry {mem_rdata, pc+4, mem_exc_code, pc} and set pc<=pc+4.
REQ-017 After a clean acknowledged fetch, the block SHALL go to FETCH; if mem_exc_code!=EC_NONE it SHALL go to HOLD instead.
REQ-018 A produced entry SHALL load the output register if stall=0 and the buffer is empty; otherwise it SHALL load the skid buffer.
REQ-019 With the buffer full, no new request SHALL be issued; at most one fetch is ever outstanding.
REQ-020 When stall=0 and the buffer is valid, the output register SHALL load the buffer and clear buffer valid.
REQ-021 When stall=0 and no entry is available, the output register SHALL load a bubble.
REQ-022 When stall=1, the output register SHALL hold its value.
REQ-023 On redirect_valid, at the same posedge: pc<=redirect_pc, skid buffer cleared, output register <= bubble (stall ignored).
REQ-024 A redirect in FETCH or HOLD SHALL send the state machine to FETCH.
REQ-025 A redirect in WAIT SHALL set discard=1 and stay in WAIT; the pending ack's data SHALL be dropped, then discard clears and the state goes to FETCH at redirect_pc.
REQ-026 A redirect coinciding with mem_ack in WAIT SHALL drop the acked data; the next cycle SHALL be FETCH at redirect_pc.
REQ-027 If redirect_valid and a produced entry occur in the same cycle, the redirect SHALL win and the entry SHALL be lost.
REQ-028 pc+4 SHALL wrap modulo 2^32 (32'hFFFFFFFC+4 = 0).
REQ-029 next_pc SHALL always equal the fetch address + 4, for use by ID in branch-target and EPC computation.

Reset
REQ-030 While rst=1, the block SHALL set pc=RESET_PC, state=FETCH, discard=0, buffer valid=0, output register=bubble, and mem_req=0.
REQ-031 Reset SHALL take priority over stall and redirect_valid.
REQ-032 Reset asserted during WAIT SHALL abandon the request (mem_req=0 next cycle); any ack arriving later SHALL be ignored.
REQ-033 The first request after reset SHALL be issued in the cycle after rst deasserts, at mem_addr=RESET_PC.

Verification
REQ-034 The bench SHALL cover reset release, mem_ack one cycle after each request with rdata=32'h24010001 -> first request at 32'hBFC00000; output instr=32'h24010001, next_pc=32'hBFC00004; next request at 32'hBFC00004.
REQ-035 The bench SHALL cover stall held for 3 cycles while two fetches are acked -> output unchanged; buffer holds the second fetch and no third request issues; on release, the outputs present in order with no loss or duplication.
REQ-036 The bench SHALL cover redirect_pc=32'h80000100 asserted in WAIT, with the ack arriving 2 cycles later carrying rdata=32'hDEADBEEF -> that data is never output; the next request is at 32'h80000100.
REQ-037 The bench SHALL cover redirect_pc=32'h80000102 -> no mem_req; output exc_code=EC_ADEL, exc_addr=32'h80000102, instr=0; fetching halts until the next redirect.
REQ-038 The bench SHALL cover an ack with mem_exc_code=EC_TLBL at pc=32'h00400000 -> output exc_code=EC_TLBL, exc_addr=32'h00400000; no further requests; redirect to 32'h80000180 resumes fetching.
REQ-039 The bench SHALL cover rst pulsed during WAIT, then a late ack -> mem_req drops; the late ack is ignored; the refetch is at RESET_PC.

Source files
------------

// File: rtl/stage_if.sv
// Instruction fetch stage: one outstanding fetch, one-entry skid buffer and an
// output register feeding ID as {instr, next_pc, exc_code, exc_addr}.
module stage_if #(
  parameter logic [31:0] RESET_PC         = 32'hBFC00000,
  parameter int          EXC_CODE_WIDTH   = 5,
  parameter int          IF2ID_WIRE_WIDTH = 96 + EXC_CODE_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        stall,
  input  logic                        redirect_valid,
  input  logic [31:0]                 redirect_pc,
  output logic                        mem_req,
  output logic [31:0]                 mem_addr,
  input  logic                        mem_ack,
  input  logic [31:0]                 mem_rdata,
  input  logic [EXC_CODE_WIDTH-1:0]   mem_exc_code,
  output logic [IF2ID_WIRE_WIDTH-1:0] interstage_if2id
);

  localparam logic [EXC_CODE_WIDTH-1:0] EC_NONE = {EXC_CODE_WIDTH{1'b1}};
  localparam logic [EXC_CODE_WIDTH-1:0] EC_ADEL = EXC_CODE_WIDTH'(4);
  localparam logic [IF2ID_WIRE_WIDTH-1:0] BUBBLE = {32'h0, 32'h0, EC_NONE, 32'h0};

  typedef enum logic [1:0] {S_FETCH, S_WAIT, S_HOLD} state_t;

  state_t                      state_q, state_d;
  logic [31:0]                 pc_q, pc_d;
  logic [31:0]                 req_addr_q, req_addr_d;
  logic                        discard_q, discard_d;
  logic                        skid_valid_q, skid_valid_d;
  logic [IF2ID_WIRE_WIDTH-1:0] skid_q, skid_d;
  logic [IF2ID_WIRE_WIDTH-1:0] out_q, out_d;
  logic                        produce;
  logic [IF2ID_WIRE_WIDTH-1:0] prod_entry;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    req_addr_d   = req_addr_q;
    discard_d    = discard_q;
    skid_valid_d = skid_valid_q;
    skid_d       = skid_q;
    out_d        = out_q;
    produce      = 1'b0;
    prod_entry   = BUBBLE;
    mem_req      = 1'b0;
    mem_addr     = req_addr_q;

    case (state_q)
      S_FETCH: begin
        mem_addr = pc_q;
        if (pc_q[1:0] != 2'b00) begin
          if (!skid_valid_q) begin
            produce    = 1'b1;
            prod_entry = {32'h0, pc_q + 32'd4, EC_ADEL, pc_q};
            state_d    = S_HOLD;
          end
        end else if (!skid_valid_q && !redirect_valid) begin
          mem_req    = 1'b1;
          req_addr_d = pc_q;
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        // address comes from req_addr_q so it stays put even after a redirect
        mem_req = 1'b1;
        if (mem_ack) begin
          if (discard_q) begin
            discard_d = 1'b0;
            state_d   = S_FETCH;
          end else begin
            produce    = 1'b1;
            prod_entry = {mem_rdata, pc_q + 32'd4, mem_exc_code, pc_q};
            pc_d       = pc_q + 32'd4;
            state_d    = (mem_exc_code == EC_NONE) ? S_FETCH : S_HOLD;
          end
        end
      end
      default: ;
    endcase

    if (!stall) begin
      if (skid_valid_q) begin
        out_d        = skid_q;
        skid_valid_d = produce;
        if (produce) skid_d = prod_entry;
      end else begin
        out_d = produce ? prod_entry : BUBBLE;
      end
    end else if (produce) begin
      skid_d       = prod_entry;
      skid_valid_d = 1'b1;
    end

    // redirect beats stall and any entry produced this cycle
    if (redirect_valid) begin
      pc_d         = redirect_pc;
      skid_valid_d = 1'b0;
      out_d        = BUBBLE;
      if (state_q == S_WAIT && !mem_ack) begin
        discard_d = 1'b1;
        state_d   = S_WAIT;
      end else begin
        discard_d = 1'b0;
        state_d   = S_FETCH;
      end
    end

    if (rst) mem_req = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_FETCH;
      pc_q         <= RESET_PC;
      req_addr_q   <= RESET_PC;
      discard_q    <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_q       <= BUBBLE;
      out_q        <= BUBBLE;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_addr_q   <= req_addr_d;
      discard_q    <= discard_d;
      skid_valid_q <= skid_valid_d;
      skid_q       <= skid_d;
      out_q        <= out_d;
    end
  end

  assign interstage_if2id = out_q;

endmodule

// File: tb/tb_stage_if.sv
// Bench for stage_if: directed scenarios plus a randomized phase, all checked
// against a transaction-level fetch/delivery model.
module tb_stage_if;

  localparam logic [31:0] RESET_PC = 32'hBFC00000;
  localparam int W = 101;
  localparam logic [4:0] EC_NONE = 5'h1F;
  localparam logic [4:0] EC_ADEL = 5'd4;
  localparam logic [4:0] EC_TLBL = 5'd2;
  localparam logic [W-1:0] BUBBLE = {32'h0, 32'h0, EC_NONE, 32'h0};

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          stall = 1'b0;
  logic          redirect_valid = 1'b0;
  logic [31:0]   redirect_pc = 32'h0;
  logic          mem_req;
  logic [31:0]   mem_addr;
  logic          mem_ack = 1'b0;
  logic [31:0]   mem_rdata = 32'h0;
  logic [4:0]    mem_exc_code = EC_NONE;
  logic [W-1:0]  if2id;

  stage_if #(.RESET_PC(RESET_PC)) dut (
    .clk              (clk),
    .rst              (rst),
    .stall            (stall),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .mem_req          (mem_req),
    .mem_addr         (mem_addr),
    .mem_ack          (mem_ack),
    .mem_rdata        (mem_rdata),
    .mem_exc_code     (mem_exc_code),
    .interstage_if2id (if2id)
  );

  always #5 clk = ~clk;

  logic [31:0] o_instr, o_npc, o_eaddr;
  logic [4:0]  o_exc;
  assign o_instr = if2id[100:69];
  assign o_npc   = if2id[68:37];
  assign o_exc   = if2id[36:32];
  assign o_eaddr = if2id[31:0];

  int checks = 0;
  int errors = 0;

  // memory responder controls
  bit          mem_auto = 1'b0;
  int          ack_lat = 1;
  bit          rd_fixed = 1'b0;
  logic [31:0] rd_value = 32'h0;
  logic [4:0]  exc_next = EC_NONE;
  logic        man_ack = 1'b0;
  logic [31:0] man_rdata = 32'h0;
  logic [31:0] salt = 32'h0;

  // reference model state
  logic [W-1:0] exp_q[$];
  logic [31:0]  m_pc = RESET_PC;
  bit           m_open = 1'b0;
  bit           m_killed = 1'b0;
  bit           m_hold = 1'b0;
  logic [31:0]  m_open_addr = 32'h0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ salt;
  endfunction

  function automatic logic [W-1:0] ent(input logic [31:0] i, input logic [31:0] n,
                                       input logic [4:0] e, input logic [31:0] a);
    return {i, n, e, a};
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic responder();
    int cnt = 0;
    forever begin
      @(posedge clk);
      #2;
      if (mem_auto) begin
        mem_ack   = 1'b0;
        mem_rdata = $urandom;
        if (mem_req && !rst) begin
          if (cnt >= ack_lat) begin
            mem_ack      = 1'b1;
            mem_rdata    = rd_fixed ? rd_value : mem_word(mem_addr);
            mem_exc_code = exc_next;
            cnt          = 0;
          end else begin
            cnt++;
          end
        end else begin
          cnt = 0;
        end
      end else begin
        cnt          = 0;
        mem_ack      = man_ack;
        mem_rdata    = man_rdata;
        mem_exc_code = EC_NONE;
      end
    end
  endtask

  // Evaluated mid-cycle: decides what the coming posedge does in terms of
  // requests issued, entries delivered to ID, and flushes.
  task automatic monitor();
    bit was_open;
    bit acked;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        m_pc     = RESET_PC;
        m_open   = 1'b0;
        m_killed = 1'b0;
        m_hold   = 1'b0;
      end else begin
        was_open = m_open;
        acked    = was_open && mem_ack;
        if (!was_open && (m_hold || m_pc[1:0] != 2'b00))
          chk("no_req_when_halted", mem_req, 1'b0);
        if (was_open) begin
          chk("req_held", mem_req, 1'b1);
          chk("addr_stable", mem_addr, m_open_addr);
        end else if (mem_req) begin
          chk("req_addr", mem_addr, m_pc);
          chk("req_room", exp_q.size() <= 1, 1'b1);
          m_open      = 1'b1;
          m_open_addr = mem_addr;
          m_killed    = 1'b0;
        end
        if (!stall && !redirect_valid && if2id !== BUBBLE) begin
          chk("out_expected", exp_q.size() != 0, 1'b1);
          if (exp_q.size() != 0) begin
            chk("out_entry", if2id, exp_q[0]);
            void'(exp_q.pop_front());
          end
        end
        if (acked) begin
          m_open = 1'b0;
          if (!m_killed && !redirect_valid) begin
            exp_q.push_back(ent(mem_rdata, m_open_addr + 32'd4, mem_exc_code, m_open_addr));
            m_pc = m_open_addr + 32'd4;
            if (mem_exc_code != EC_NONE) m_hold = 1'b1;
          end
        end
        if (redirect_valid) begin
          exp_q.delete();
          m_pc   = redirect_pc;
          m_hold = 1'b0;
          if (m_open) m_killed = 1'b1;
        end else if (!was_open && !m_hold && m_pc[1:0] != 2'b00) begin
          exp_q.push_back(ent(32'h0, m_pc + 32'd4, EC_ADEL, m_pc));
          m_hold = 1'b1;
        end
      end
    end
  endtask

  task automatic do_reset();
    next_cycle();
    rst = 1'b1;
    next_cycle();
  endtask

  initial begin
    logic [31:0] rnd;
    salt = $urandom;
    fork
      responder();
      monitor();
    join_none

    // reset state
    repeat (3) next_cycle();
    @(negedge clk);
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_out_bubble", if2id, BUBBLE);

    // first fetches after reset release, ack one cycle after each request
    mem_auto = 1'b1; ack_lat = 1; rd_fixed = 1'b1; rd_value = 32'h24010001;
    next_cycle(); rst = 1'b0;
    @(negedge clk);
    chk("first_req", mem_req, 1'b1);
    chk("first_addr", mem_addr, RESET_PC);
    next_cycle();
    @(negedge clk);
    chk("first_addr_held", mem_addr, RESET_PC);
    next_cycle();
    @(negedge clk);
    chk("first_instr", o_instr, 32'h24010001);
    chk("first_npc", o_npc, 32'hBFC00004);
    chk("first_exc", o_exc, EC_NONE);
    chk("first_eaddr", o_eaddr, RESET_PC);
    chk("second_req", mem_req, 1'b1);
    chk("second_addr", mem_addr, 32'hBFC00004);
    rd_fixed = 1'b0;

    // stall for three cycles across two acks
    do_reset();
    next_cycle(); rst = 1'b0;
    next_cycle();
    next_cycle(); stall = 1'b1;
    @(negedge clk);
    chk("stall_out_a0", o_instr, mem_word(RESET_PC));
    chk("stall_req_b", mem_addr, 32'hBFC00004);
    next_cycle();
    @(negedge clk);
    chk("stall_out_a1", o_instr, mem_word(RESET_PC));
    next_cycle();
    @(negedge clk);
    chk("stall_out_a2", o_instr, mem_word(RESET_PC));
    chk("stall_no_third_req", mem_req, 1'b0);
    next_cycle(); stall = 1'b0;
    @(negedge clk);
    chk("release_out_a", o_instr, mem_word(RESET_PC));
    chk("release_no_req", mem_req, 1'b0);
    next_cycle();
    @(negedge clk);
    chk("release_out_b", if2id, ent(mem_word(32'hBFC00004), 32'hBFC00008, EC_NONE, 32'hBFC00004));
    chk("release_req_c", mem_addr, 32'hBFC00008);
    chk("release_req_c_valid", mem_req, 1'b1);
    next_cycle();
    @(negedge clk);
    chk("release_no_dup", if2id, BUBBLE);

    // redirect while waiting; late ack data must vanish
    mem_auto = 1'b0; man_ack = 1'b0;
    do_reset();
    next_cycle(); rst = 1'b0;
    @(negedge clk);
    chk("wr_req", mem_addr, RESET_PC);
    next_cycle(); redirect_valid = 1'b1; redirect_pc = 32'h80000100;
    next_cycle(); redirect_valid = 1'b0;
    @(negedge clk);
    chk("wr_addr_held", mem_addr, RESET_PC);
    chk("wr_out_bubble", if2id, BUBBLE);
    next_cycle(); man_ack = 1'b1; man_rdata = 32'hDEADBEEF;
    next_cycle(); man_ack = 1'b0; mem_auto = 1'b1; ack_lat = 1;
    @(negedge clk);
    chk("wr_out_dropped", if2id, BUBBLE);
    chk("wr_refetch_req", mem_req, 1'b1);
    chk("wr_refetch_addr", mem_addr, 32'h80000100);
    next_cycle();
    next_cycle();
    @(negedge clk);
    chk("wr_new_instr", o_instr, mem_word(32'h80000100));

    // misaligned redirect target
    do_reset();
    next_cycle(); rst = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h80000102;
    @(negedge clk);
    chk("adel_no_req0", mem_req, 1'b0);
    next_cycle(); redirect_valid = 1'b0;
    @(negedge clk);
    chk("adel_no_req1", mem_req, 1'b0);
    next_cycle();
    @(negedge clk);
    chk("adel_entry", if2id, ent(32'h0, 32'h80000106, EC_ADEL, 32'h80000102));
    for (int i = 0; i < 5; i++) begin
      next_cycle();
      @(negedge clk);
      chk("adel_halt", mem_req, 1'b0);
    end

    // fetch fault, halt, then resume on redirect
    next_cycle(); redirect_valid = 1'b1; redirect_pc = 32'h00400000; exc_next = EC_TLBL;
    next_cycle(); redirect_valid = 1'b0;
    @(negedge clk);
    chk("tlb_req", mem_addr, 32'h00400000);
    next_cycle();
    next_cycle(); exc_next = EC_NONE;
    @(negedge clk);
    chk("tlb_entry", if2id, ent(mem_word(32'h00400000), 32'h00400004, EC_TLBL, 32'h00400000));
    chk("tlb_no_req", mem_req, 1'b0);
    repeat (4) next_cycle();
    @(negedge clk);
    chk("tlb_halt", mem_req, 1'b0);
    next_cycle(); mem_auto = 1'b0; man_ack = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h80000180;
    next_cycle(); redirect_valid = 1'b0;
    @(negedge clk);
    chk("tlb_resume_req", mem_req, 1'b1);
    chk("tlb_resume_addr", mem_addr, 32'h80000180);

    // reset during a wait, late ack ignored
    next_cycle(); rst = 1'b1;
    @(negedge clk);
    chk("rw_req_drop", mem_req, 1'b0);
    next_cycle(); man_ack = 1'b1; man_rdata = 32'hCAFEF00D;
    @(negedge clk);
    chk("rw_req_low", mem_req, 1'b0);
    next_cycle(); rst = 1'b0; man_ack = 1'b0; mem_auto = 1'b1; ack_lat = 1;
    @(negedge clk);
    chk("rw_refetch", mem_addr, RESET_PC);
    chk("rw_refetch_req", mem_req, 1'b1);
    chk("rw_out_bubble", if2id, BUBBLE);
    next_cycle();
    next_cycle();
    @(negedge clk);
    chk("rw_out", if2id, ent(mem_word(RESET_PC), 32'hBFC00004, EC_NONE, RESET_PC));

    // pc wraps past the top of the address space
    do_reset();
    next_cycle(); rst = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'hFFFFFFFC;
    next_cycle(); redirect_valid = 1'b0;
    @(negedge clk);
    chk("wrap_req", mem_addr, 32'hFFFFFFFC);
    next_cycle();
    next_cycle();
    @(negedge clk);
    chk("wrap_npc", o_npc, 32'h0);
    chk("wrap_next_addr", mem_addr, 32'h0);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      next_cycle();
      stall          = ($urandom_range(0, 3) == 0);
      ack_lat        = $urandom_range(1, 3);
      exc_next       = ($urandom_range(0, 19) == 0) ? EC_TLBL : EC_NONE;
      redirect_valid = ($urandom_range(0, 24) == 0);
      rnd            = $urandom;
      rnd[1:0]       = ($urandom_range(0, 7) == 0) ? 2'b10 : 2'b00;
      redirect_pc    = rnd;
    end

    // drain
    next_cycle();
    stall = 1'b0; redirect_valid = 1'b0; exc_next = EC_NONE;
    mem_auto = 1'b0; man_ack = 1'b0;
    repeat (6) next_cycle();
    @(negedge clk);
    chk("drain_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
